// File: rtl/divider_pkg.sv
// Shared definitions for the restoring-divider sequencer: state encoding,
// remainder write codes, ALU op codes, the registered control word and its
// per-state decode.
// No ports (package).
package divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SUB     = 3'd2,
        S_SHL1    = 3'd3,
        S_RESTORE = 3'd4,
        S_ZERO    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Remainder register write codes
    localparam logic [1:0] CTRL_LOAD_SHL     = 2'b00;
    localparam logic [1:0] CTRL_SUB          = 2'b01;
    localparam logic [1:0] CTRL_SHL1         = 2'b10;
    localparam logic [1:0] CTRL_RESTORE_SHL0 = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Control word driven toward the datapath (div_zero is kept separately
    // because it is sticky rather than a pure state decode)
    typedef struct packed {
        logic [1:0] w_ctrl_reg2;
        logic       reg2_we;
        logic       w_ctrl_reg1;
        logic       alu_op;
        logic       busy;
        logic       rdy;
    } ctrl_out_t;

    // Output decode for a given state; unknown encodings decode to all-zero
    function automatic ctrl_out_t decode_state(input state_t s);
        ctrl_out_t o;
        o = '0;
        case (s)
            S_LOAD: begin
                o.w_ctrl_reg2 = CTRL_LOAD_SHL;
                o.reg2_we     = 1'b1;
                o.w_ctrl_reg1 = 1'b1;
                o.busy        = 1'b1;
            end
            S_SUB: begin
                o.w_ctrl_reg2 = CTRL_SUB;
                o.alu_op      = ALU_SUB;
                o.reg2_we     = 1'b1;
                o.busy        = 1'b1;
            end
            S_SHL1: begin
                o.w_ctrl_reg2 = CTRL_SHL1;
                o.reg2_we     = 1'b1;
                o.busy        = 1'b1;
            end
            S_RESTORE: begin
                o.w_ctrl_reg2 = CTRL_RESTORE_SHL0;
                o.alu_op      = ALU_ADD;
                o.reg2_we     = 1'b1;
                o.busy        = 1'b1;
            end
            S_ZERO: begin
                o.busy = 1'b1;
            end
            S_DONE: begin
                o.rdy = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/divider_control_if.sv
// Bundle between the divider sequencer and its environment (CPU handshake,
// remainder register and ALU).
//  start, divisor_zero : CPU request and operand flag (sampled together)
//  sign_flag           : remainder MSB fed back from the remainder register
//  w_ctrl_reg2, reg2_we, w_ctrl_reg1, alu_op : datapath control
//  busy, rdy, div_zero : status back to the CPU
// modport slave  : the sequencer
// modport master : the surrounding CPU/datapath
interface divider_control_if;

    logic       start;
    logic       divisor_zero;
    logic       sign_flag;
    logic [1:0] w_ctrl_reg2;
    logic       reg2_we;
    logic       w_ctrl_reg1;
    logic       alu_op;
    logic       busy;
    logic       rdy;
    logic       div_zero;

    modport master (
        output start, divisor_zero, sign_flag,
        input  w_ctrl_reg2, reg2_we, w_ctrl_reg1, alu_op, busy, rdy, div_zero
    );

    modport slave (
        input  start, divisor_zero, sign_flag,
        output w_ctrl_reg2, reg2_we, w_ctrl_reg1, alu_op, busy, rdy, div_zero
    );

endinterface

// File: rtl/div_iter_counter.sv
// Iteration counter for the divider sequencer: synchronous clear, saturating
// increment and a registered "last iteration" flag (count == WIDTH-1).
//  clk     : clock
//  rst     : synchronous active-low reset
//  clr_i   : force count to 0
//  inc_i   : advance count (held once the last value is reached)
//  last_o  : count currently equals WIDTH-1
module div_iter_counter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    if ((64'(1) << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
        $error("div_iter_counter: CNT_W too small for WIDTH");
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic             last_q, last_d;

    // Saturating next-count so the counter can never pass WIDTH-1 or wrap
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !last_q) begin
            count_d = count_q + CNT_W'(1);
        end
        last_d = (count_d == LAST_VAL);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign last_o = last_q;

endmodule

// File: rtl/divider_control.sv
// Sequencer for the 32-bit unsigned restoring divider. Loads the remainder
// register, then alternates SUB with SHL1/RESTORE based on the remainder sign
// for WIDTH iterations, flags divide-by-zero and handshakes start/rdy.
//  clk  : clock, controller updates on posedge
//  rst  : synchronous active-low reset
//  bus  : divider_control_if.slave (start, divisor_zero, sign_flag in;
//         w_ctrl_reg2, reg2_we, w_ctrl_reg1, alu_op, busy, rdy, div_zero out)
module divider_control
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    divider_control_if.slave   bus
);

    state_t    state_q, state_d;
    ctrl_out_t out_q, out_d;
    logic      div_zero_q, div_zero_d;
    logic      cnt_clr, cnt_inc, cnt_last;

    div_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .last_o (cnt_last)
    );

    // Next-state, counter control and registered-output decode
    always_comb begin
        state_d    = state_q;
        div_zero_d = div_zero_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = bus.divisor_zero ? S_ZERO : S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_clr = 1'b1;
                state_d = S_SUB;
            end
            S_SUB: begin
                // sign_flag reflects the subtract written on the previous negedge
                state_d = bus.sign_flag ? S_RESTORE : S_SHL1;
            end
            S_SHL1, S_RESTORE: begin
                cnt_inc = 1'b1;
                state_d = cnt_last ? S_DONE : S_SUB;
            end
            S_ZERO: begin
                div_zero_d = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (bus.start) begin
                    div_zero_d = 1'b0;
                    state_d    = bus.divisor_zero ? S_ZERO : S_LOAD;
                end
            end
            default: begin
                state_d    = S_IDLE;
                div_zero_d = 1'b0;
            end
        endcase

        // Outputs registered from the next state so they are valid at the posedge
        out_d = decode_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            out_q      <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.w_ctrl_reg2 = out_q.w_ctrl_reg2;
    assign bus.reg2_we     = out_q.reg2_we;
    assign bus.w_ctrl_reg1 = out_q.w_ctrl_reg1;
    assign bus.alu_op      = out_q.alu_op;
    assign bus.busy        = out_q.busy;
    assign bus.rdy         = out_q.rdy;
    assign bus.div_zero    = div_zero_q;

endmodule

// File: tb/tb_divider_control.sv
// Bench for divider_control with a behavioural remainder register / ALU model.
module tb_divider_control;

    localparam logic [7:0] V_ZERO_OUT = 8'b00_0_0_0_0_0_0;
    localparam logic [7:0] V_LOAD     = 8'b00_1_1_0_1_0_0;
    localparam logic [7:0] V_ZEROST   = 8'b00_0_0_0_1_0_0;
    localparam logic [7:0] V_DONE     = 8'b00_0_0_0_0_1_0;
    localparam logic [7:0] V_DONE_DZ  = 8'b00_0_0_0_0_1_1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_control_if dif ();

    divider_control #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural remainder register (bit 64 = sign) and ALU
    logic [64:0] rem         = '0;
    logic [31:0] divisor_reg = '0;
    logic [31:0] dividend    = '0;
    logic [31:0] divisor     = '0;
    logic [32:0] alu_res;
    logic        force_en    = 1'b0;
    logic        force_val   = 1'b0;

    int we_cnt = 0, sub_cnt = 0, shl1_cnt = 0, restore_cnt = 0, load_cnt = 0;

    assign alu_res       = dif.alu_op ? (rem[64:32] - {1'b0, divisor_reg})
                                      : (rem[64:32] + {1'b0, divisor_reg});
    assign dif.sign_flag = force_en ? force_val : rem[64];

    always @(negedge clk) begin
        if (dif.w_ctrl_reg1) begin
            divisor_reg <= divisor;
            load_cnt++;
        end
        if (dif.reg2_we) begin
            we_cnt++;
            case (dif.w_ctrl_reg2)
                2'b00: rem <= {33'b0, dividend} << 1;
                2'b01: begin
                    rem <= {alu_res, rem[31:0]};
                    if (dif.alu_op) sub_cnt++;
                end
                2'b10: begin
                    rem <= {rem[63:0], 1'b1};
                    shl1_cnt++;
                end
                default: begin
                    rem <= {alu_res[31:0], rem[31:0], 1'b0};
                    if (!dif.alu_op) restore_cnt++;
                end
            endcase
        end
    end

    function automatic logic [7:0] outs();
        return {dif.w_ctrl_reg2, dif.reg2_we, dif.w_ctrl_reg1, dif.alu_op,
                dif.busy, dif.rdy, dif.div_zero};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] dvd, input logic [31:0] dvs);
        dividend         = dvd;
        divisor          = dvs;
        dif.divisor_zero = (dvs == 32'd0);
        dif.start        = 1'b1;
    endtask

    // Counts posedges from the one that samples start until rdy is seen
    task automatic run_to_rdy(input int p1, input int p2, output int n,
                              output logic [7:0] first);
        n     = 0;
        first = '0;
        do begin
            tick();
            n++;
            if (n == 1) first = outs();
            dif.start = (n == p1) || (n == p2);
            dif.divisor_zero = 1'b0;
        end while (!dif.rdy && n < 200);
        dif.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        dif.start = 1'b0;
        dif.divisor_zero = 1'b0;
        repeat (3) tick();
        tests++;
        if (outs() !== V_ZERO_OUT) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b", outs(), V_ZERO_OUT);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (outs() !== V_ZERO_OUT) begin
            fails++;
            $display("FAIL idle_outputs: got %b expected %b", outs(), V_ZERO_OUT);
        end
    endtask

    task automatic test_basic_100_7();
        int n, s0, r0, h0;
        logic [7:0] first;
        s0 = sub_cnt; r0 = restore_cnt; h0 = shl1_cnt;
        launch(32'd100, 32'd7);
        run_to_rdy(0, 0, n, first);
        tests++;
        if (first !== V_LOAD) begin
            fails++;
            $display("FAIL basic_load_decode: got %b expected %b", first, V_LOAD);
        end
        tests++;
        if (n !== 66) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 66", n);
        end
        tests++;
        if (rem[31:0] !== 32'd14) begin
            fails++;
            $display("FAIL basic_quotient: got %0d expected 14", rem[31:0]);
        end
        tests++;
        if (rem[64:33] !== 32'd2) begin
            fails++;
            $display("FAIL basic_remainder: got %0d expected 2", rem[64:33]);
        end
        tests++;
        if (sub_cnt - s0 !== 32) begin
            fails++;
            $display("FAIL basic_sub_count: got %0d expected 32", sub_cnt - s0);
        end
        tests++;
        if ((restore_cnt - r0) + (shl1_cnt - h0) !== 32) begin
            fails++;
            $display("FAIL basic_shift_count: got %0d expected 32",
                     (restore_cnt - r0) + (shl1_cnt - h0));
        end
        repeat (4) tick();
        tests++;
        if (outs() !== V_DONE) begin
            fails++;
            $display("FAIL basic_done_hold: got %b expected %b", outs(), V_DONE);
        end
    endtask

    task automatic test_div_zero();
        int n, w0, s0;
        logic [7:0] first;
        w0 = we_cnt; s0 = sub_cnt;
        launch(32'd5, 32'd0);
        run_to_rdy(0, 0, n, first);
        tests++;
        if (first !== V_ZEROST) begin
            fails++;
            $display("FAIL zero_state_decode: got %b expected %b", first, V_ZEROST);
        end
        tests++;
        if (n !== 2) begin
            fails++;
            $display("FAIL zero_latency: got %0d expected 2", n);
        end
        tests++;
        if (outs() !== V_DONE_DZ) begin
            fails++;
            $display("FAIL zero_done_flags: got %b expected %b", outs(), V_DONE_DZ);
        end
        tests++;
        if ((we_cnt - w0) !== 0 || (sub_cnt - s0) !== 0) begin
            fails++;
            $display("FAIL zero_no_writes: got we=%0d sub=%0d expected 0/0",
                     we_cnt - w0, sub_cnt - s0);
        end
    endtask

    // Entered from DONE with div_zero=1 left by the previous test
    task automatic test_start_in_done();
        int n;
        logic [7:0] first;
        launch(32'hFFFF_FFFF, 32'd1);
        run_to_rdy(0, 0, n, first);
        tests++;
        if (first !== V_LOAD) begin
            fails++;
            $display("FAIL done_restart_edge: got %b expected %b", first, V_LOAD);
        end
        tests++;
        if (n !== 66) begin
            fails++;
            $display("FAIL done_restart_latency: got %0d expected 66", n);
        end
        tests++;
        if (rem[31:0] !== 32'hFFFF_FFFF || rem[64:33] !== 32'd0) begin
            fails++;
            $display("FAIL done_restart_result: got q=%h r=%h expected ffffffff/0",
                     rem[31:0], rem[64:33]);
        end
        tests++;
        if (outs() !== V_DONE) begin
            fails++;
            $display("FAIL done_restart_flags: got %b expected %b", outs(), V_DONE);
        end
    endtask

    task automatic test_busy_ignore();
        int n, l0;
        logic [7:0] first;
        l0 = load_cnt;
        launch(32'd1000, 32'd10);
        run_to_rdy(5, 40, n, first);
        tests++;
        if (n !== 66) begin
            fails++;
            $display("FAIL busy_ignore_latency: got %0d expected 66", n);
        end
        tests++;
        if (load_cnt - l0 !== 1) begin
            fails++;
            $display("FAIL busy_ignore_loads: got %0d expected 1", load_cnt - l0);
        end
        tests++;
        if (rem[31:0] !== 32'd100 || rem[64:33] !== 32'd0) begin
            fails++;
            $display("FAIL busy_ignore_result: got q=%0d r=%0d expected 100/0",
                     rem[31:0], rem[64:33]);
        end
    endtask

    task automatic test_sign_forced();
        int n, r0, h0;
        logic [7:0] first;
        force_en = 1'b1;
        for (int v = 1; v >= 0; v--) begin
            force_val = v[0];
            r0 = restore_cnt; h0 = shl1_cnt;
            launch(32'd100, 32'd7);
            run_to_rdy(0, 0, n, first);
            tests++;
            if (n !== 66) begin
                fails++;
                $display("FAIL sign%0d_latency: got %0d expected 66", v, n);
            end
            tests++;
            if ((restore_cnt - r0) !== 32 * v || (shl1_cnt - h0) !== 32 * (1 - v)) begin
                fails++;
                $display("FAIL sign%0d_codes: got restore=%0d shl1=%0d expected %0d/%0d",
                         v, restore_cnt - r0, shl1_cnt - h0, 32 * v, 32 * (1 - v));
            end
        end
        force_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n, w0;
        logic [7:0] first;
        launch(32'd100, 32'd7);
        n = 0;
        while (n < 20) begin
            tick();
            n++;
            dif.start = 1'b0;
            dif.divisor_zero = 1'b0;
        end
        rst = 1'b0;
        tick();
        tests++;
        if (outs() !== V_ZERO_OUT) begin
            fails++;
            $display("FAIL abort_outputs: got %b expected %b", outs(), V_ZERO_OUT);
        end
        w0 = we_cnt;
        rst = 1'b1;
        tick();
        tests++;
        if (outs() !== V_ZERO_OUT || we_cnt !== w0) begin
            fails++;
            $display("FAIL abort_idle: got %b we_delta=%0d expected %b/0",
                     outs(), we_cnt - w0, V_ZERO_OUT);
        end
        launch(32'd100, 32'd7);
        run_to_rdy(0, 0, n, first);
        tests++;
        if (n !== 66 || rem[31:0] !== 32'd14 || rem[64:33] !== 32'd2) begin
            fails++;
            $display("FAIL abort_rerun: got n=%0d q=%0d r=%0d expected 66/14/2",
                     n, rem[31:0], rem[64:33]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_100_7();
        test_div_zero();
        test_start_in_done();
        test_busy_ignore();
        test_sign_forced();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
